// File: rtl/crypto_pkg.sv
// Shared types, widths and the Feistel F function for the OTTER crypto sequencer.
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROT    = 3;
  localparam int KEY_W  = 64;
  localparam int HALF_W = 16;

  // F(x, K) = ((x rotl ROT) ^ K) + x, wrapping at HALF_W bits.
  function automatic logic [HALF_W-1:0] f_round(input logic [HALF_W-1:0] x,
                                                input logic [HALF_W-1:0] k);
    logic [HALF_W-1:0] rot;
    rot = (x << ROT) | (x >> (HALF_W - ROT));
    return (rot ^ k) + x;
  endfunction

endpackage

// File: rtl/otter_crypto_seq_if.sv
// Decoder-side request bus and pipeline-side result bus of the crypto sequencer.
// START is the request; it is taken in any IDLE/DONE cycle with ABORT low, STALL
// is high while a request is not yet finished, and DONE pulses once per completed request.
interface otter_crypto_seq_if;
  logic        START;
  logic        DECRYPT;
  logic [31:0] DATA_IN;
  logic        KEY_WE;
  logic [63:0] KEY_IN;
  logic        ABORT;
  logic        STALL;
  logic        DONE;
  logic [31:0] RESULT;
  logic        BUSY;

  modport master (
    output START, DECRYPT, DATA_IN, KEY_WE, KEY_IN, ABORT,
    input  STALL, DONE, RESULT, BUSY
  );

  modport slave (
    input  START, DECRYPT, DATA_IN, KEY_WE, KEY_IN, ABORT,
    output STALL, DONE, RESULT, BUSY
  );
endinterface

// File: rtl/crypto_round.sv
// One combinational 16/16 Feistel round; mode_i = 1 applies the inverse round.
module crypto_round
  import crypto_pkg::*;
(
  input  logic [2*HALF_W-1:0] lr_i,
  input  logic [HALF_W-1:0]   k_i,
  input  logic                mode_i,
  output logic [2*HALF_W-1:0] lr_o
);

  logic [HALF_W-1:0] l;
  logic [HALF_W-1:0] r;

  assign l = lr_i[2*HALF_W-1:HALF_W];
  assign r = lr_i[HALF_W-1:0];

  always_comb begin
    if (mode_i) begin
      lr_o = {r ^ f_round(l, k_i), l};
    end else begin
      lr_o = {r, l ^ f_round(r, k_i)};
    end
  end

endmodule

// File: rtl/otter_crypto_seq.sv
// Multi-cycle ENCRY sequencer: owns the key, round counter, working and result
// registers, runs NROUNDS Feistel rounds per request and stalls the pipeline meanwhile.
module otter_crypto_seq
  import crypto_pkg::*;
#(
  parameter int NROUNDS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  otter_crypto_seq_if.slave   bus,
  output state_t              dbg_state
);

  localparam logic [4:0] LAST = 5'(NROUNDS - 1);

  state_t              state_q, state_d;
  logic [4:0]          i_q, i_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [31:0]         work_q, work_d;
  logic                mode_q, mode_d;
  logic [31:0]         result_q, result_d;

  logic                accept;
  logic [1:0]          j_lo;
  logic [1:0]          k_idx;
  logic [HALF_W-1:0]   sub_key;
  logic [31:0]         round_out;

  // Decrypt walks the subkeys backwards; only index mod 4 matters, so 2-bit math suffices.
  assign j_lo    = LAST[1:0] - i_q[1:0];
  assign k_idx   = mode_q ? j_lo : i_q[1:0];
  assign sub_key = key_q[{k_idx, 4'b0000} +: HALF_W];

  crypto_round u_round (
    .lr_i   (work_q),
    .k_i    (sub_key),
    .mode_i (mode_q),
    .lr_o   (round_out)
  );

  assign accept = bus.START & ~bus.ABORT & (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    key_d    = key_q;
    work_d   = work_q;
    mode_d   = mode_q;
    result_d = result_q;
    case (state_q)
      RUN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
          i_d     = '0;
        end else begin
          work_d = round_out;
          i_d    = i_q + 5'd1;
          // The final round's output goes straight to RESULT so it is valid in the DONE cycle.
          if (i_q == LAST) begin
            state_d  = DONE;
            result_d = round_out;
            i_d      = '0;
          end
        end
      end
      default: begin
        if (bus.KEY_WE) key_d = bus.KEY_IN;
        if (accept) begin
          work_d  = bus.DATA_IN;
          mode_d  = bus.DECRYPT;
          i_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      i_q      <= '0;
      key_q    <= '0;
      work_q   <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      key_q    <= key_d;
      work_q   <= work_d;
      mode_q   <= mode_d;
      result_q <= result_d;
    end
  end

  // STALL is combinational so the accepting cycle already holds the PC.
  assign bus.STALL  = accept | (state_q == RUN);
  assign bus.DONE   = (state_q == DONE);
  assign bus.BUSY   = (state_q == RUN);
  assign bus.RESULT = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_otter_crypto_seq.sv
// Directed bench for otter_crypto_seq: a 1-round and an 8-round instance.
module tb_otter_crypto_seq;
  import crypto_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_crypto_seq_if bus1();
  otter_crypto_seq_if bus8();
  state_t st1, st8;

  otter_crypto_seq #(.NROUNDS(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(bus1), .dbg_state(st1)
  );
  otter_crypto_seq #(.NROUNDS(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .bus(bus8), .dbg_state(st8)
  );

  int checks = 0;
  int errors = 0;
  int done8  = 0;
  logic [31:0] last_exp8;
  logic [63:0] key8_model;

  localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K2 = 64'hFEDC_BA98_7654_3210;

  always @(negedge clk) if (bus8.DONE === 1'b1) done8++;

  function automatic logic [15:0] ref_f(input logic [15:0] x, input logic [15:0] k);
    logic [15:0] rot;
    rot = {x[12:0], x[15:13]};
    return (rot ^ k) + x;
  endfunction

  function automatic logic [31:0] ref_cipher(input logic [31:0] d, input logic [63:0] k,
                                             input logic dec, input int n);
    logic [15:0] l, r, kk, t;
    int j;
    l = d[31:16];
    r = d[15:0];
    for (int i = 0; i < n; i++) begin
      j  = dec ? (n - 1 - i) : i;
      kk = k[16*(j%4) +: 16];
      if (!dec) begin
        t = l ^ ref_f(r, kk); l = r; r = t;
      end else begin
        t = r ^ ref_f(l, kk); r = l; l = t;
      end
    end
    return {l, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.START = 0; bus1.DECRYPT = 0; bus1.DATA_IN = '0; bus1.KEY_WE = 0; bus1.KEY_IN = '0; bus1.ABORT = 0;
    bus8.START = 0; bus8.DECRYPT = 0; bus8.DATA_IN = '0; bus8.KEY_WE = 0; bus8.KEY_IN = '0; bus8.ABORT = 0;
  endtask

  // Issues one request on the 8-round instance; lat = cycles from START to DONE, -1 on timeout.
  task automatic run_op8(input logic dec, input logic [31:0] d, output int lat,
                         output logic [31:0] res, output logic stall_at_done);
    bus8.START = 1; bus8.DECRYPT = dec; bus8.DATA_IN = d;
    tick();
    bus8.START = 0;
    lat = 1;
    while (bus8.DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus8.DONE !== 1'b1) lat = -1;
    res = bus8.RESULT;
    stall_at_done = bus8.STALL;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++; if (st8 !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st8, IDLE); end
    checks++; if (bus8.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus8.DONE); end
    checks++; if (bus8.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus8.BUSY); end
    checks++; if (bus8.RESULT !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus8.RESULT); end
    checks++; if (bus8.STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus8.STALL); end
    checks++; if (bus1.RESULT !== 32'h0) begin errors++; $display("FAIL reset_result1: got %h expected 0", bus1.RESULT); end
    tick(); tick();
    rst_n = 1;
    key8_model = '0;
    last_exp8 = '0;
    tick();
  endtask

  task automatic test_one_round();
    bus1.START = 1; bus1.DECRYPT = 0; bus1.DATA_IN = 32'h0001_0002;
    #1;
    checks++; if (bus1.STALL !== 1'b1) begin errors++; $display("FAIL r1_stall_t0: got %b expected 1", bus1.STALL); end
    tick();
    bus1.START = 0;
    #1;
    checks++; if (bus1.STALL !== 1'b1) begin errors++; $display("FAIL r1_stall_t1: got %b expected 1", bus1.STALL); end
    checks++; if (bus1.BUSY !== 1'b1) begin errors++; $display("FAIL r1_busy_t1: got %b expected 1", bus1.BUSY); end
    tick();
    checks++; if (bus1.DONE !== 1'b1) begin errors++; $display("FAIL r1_done_t2: got %b expected 1", bus1.DONE); end
    checks++; if (bus1.RESULT !== 32'h0002_0013) begin errors++; $display("FAIL r1_result: got %h expected 00020013", bus1.RESULT); end
    checks++; if (bus1.STALL !== 1'b0) begin errors++; $display("FAIL r1_stall_t2: got %b expected 0", bus1.STALL); end
    tick();
    checks++; if (bus1.DONE !== 1'b0) begin errors++; $display("FAIL r1_done_t3: got %b expected 0", bus1.DONE); end
    checks++; if (bus1.RESULT !== 32'h0002_0013) begin errors++; $display("FAIL r1_result_hold: got %h expected 00020013", bus1.RESULT); end
  endtask

  task automatic test_enc_dec();
    int lat;
    logic [31:0] res, exp_v;
    logic sd;
    bus8.KEY_WE = 1; bus8.KEY_IN = K1;
    tick();
    bus8.KEY_WE = 0;
    key8_model = K1;
    exp_v = ref_cipher(32'hDEAD_BEEF, key8_model, 1'b0, 8);
    run_op8(1'b0, 32'hDEAD_BEEF, lat, res, sd);
    checks++; if (lat != 9) begin errors++; $display("FAIL enc_latency: got %0d expected 9", lat); end
    checks++; if (res !== exp_v) begin errors++; $display("FAIL enc_result: got %h expected %h", res, exp_v); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL enc_stall_done: got %b expected 0", sd); end
    run_op8(1'b1, exp_v, lat, res, sd);
    checks++; if (lat != 9) begin errors++; $display("FAIL dec_latency: got %0d expected 9", lat); end
    checks++; if (res !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dec_roundtrip: got %h expected deadbeef", res); end
    last_exp8 = 32'hDEAD_BEEF;
  endtask

  task automatic test_abort();
    int d0;
    d0 = done8;
    bus8.START = 1; bus8.DECRYPT = 0; bus8.DATA_IN = 32'h0BAD_F00D;
    tick();
    bus8.START = 0;
    tick(); tick();
    bus8.ABORT = 1;
    #1;
    checks++; if (bus8.STALL !== 1'b1) begin errors++; $display("FAIL abort_stall_t3: got %b expected 1", bus8.STALL); end
    tick();
    bus8.ABORT = 0;
    #1;
    checks++; if (st8 !== IDLE) begin errors++; $display("FAIL abort_state_t4: got %0d expected %0d", st8, IDLE); end
    checks++; if (bus8.STALL !== 1'b0) begin errors++; $display("FAIL abort_stall_t4: got %b expected 0", bus8.STALL); end
    checks++; if (bus8.RESULT !== last_exp8) begin errors++; $display("FAIL abort_result_hold: got %h expected %h", bus8.RESULT, last_exp8); end
    repeat (12) tick();
    checks++; if (done8 != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done8 - d0); end
    bus8.START = 1; bus8.ABORT = 1; bus8.DATA_IN = 32'h1357_9BDF;
    #1;
    checks++; if (bus8.STALL !== 1'b0) begin errors++; $display("FAIL abort_vs_start_stall: got %b expected 0", bus8.STALL); end
    tick();
    bus8.START = 0; bus8.ABORT = 0;
    #1;
    checks++; if (st8 !== IDLE) begin errors++; $display("FAIL abort_vs_start_state: got %0d expected %0d", st8, IDLE); end
  endtask

  task automatic test_key_during_run();
    int n, lat;
    logic [31:0] exp_old, exp_new, res;
    logic sd;
    exp_old = ref_cipher(32'h1234_5678, key8_model, 1'b0, 8);
    bus8.START = 1; bus8.DECRYPT = 0; bus8.DATA_IN = 32'h1234_5678;
    tick();
    bus8.START = 0;
    tick();
    bus8.KEY_WE = 1; bus8.KEY_IN = K2;
    tick();
    bus8.KEY_WE = 0;
    n = 3;
    while (bus8.DONE !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (bus8.DONE !== 1'b1) begin errors++; $display("FAIL keyrun_done: got %b expected 1", bus8.DONE); end
    checks++; if (bus8.RESULT !== exp_old) begin errors++; $display("FAIL keyrun_result: got %h expected %h", bus8.RESULT, exp_old); end
    tick();
    bus8.KEY_WE = 1; bus8.KEY_IN = K2;
    tick();
    bus8.KEY_WE = 0;
    key8_model = K2;
    exp_new = ref_cipher(32'h1234_5678, key8_model, 1'b0, 8);
    run_op8(1'b0, 32'h1234_5678, lat, res, sd);
    checks++; if (res !== exp_new) begin errors++; $display("FAIL keyidle_result: got %h expected %h", res, exp_new); end
    last_exp8 = exp_new;
  endtask

  task automatic test_back_to_back();
    int n, m;
    logic [31:0] exp_a, exp_b;
    exp_a = ref_cipher(32'hCAFE_0001, key8_model, 1'b0, 8);
    exp_b = ref_cipher(32'h5A5A_A5A5, key8_model, 1'b1, 8);
    bus8.START = 1; bus8.DECRYPT = 0; bus8.DATA_IN = 32'hCAFE_0001;
    tick();
    bus8.DECRYPT = 1; bus8.DATA_IN = 32'h5A5A_A5A5;
    n = 1;
    while (bus8.DONE !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", n); end
    checks++; if (bus8.RESULT !== exp_a) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", bus8.RESULT, exp_a); end
    checks++; if (bus8.STALL !== 1'b1) begin errors++; $display("FAIL b2b_stall_done: got %b expected 1", bus8.STALL); end
    tick();
    bus8.START = 0;
    m = 1;
    while (bus8.DONE !== 1'b1 && m < 40) begin tick(); m++; end
    checks++; if (m != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", m); end
    checks++; if (bus8.RESULT !== exp_b) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", bus8.RESULT, exp_b); end
    tick();
    last_exp8 = exp_b;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [31:0] res, exp_v;
    logic sd;
    bus8.START = 1; bus8.DECRYPT = 0; bus8.DATA_IN = 32'h1111_2222;
    tick();
    bus8.START = 0;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    checks++; if (st8 !== IDLE) begin errors++; $display("FAIL rst_run_state: got %0d expected %0d", st8, IDLE); end
    checks++; if (bus8.RESULT !== 32'h0) begin errors++; $display("FAIL rst_run_result: got %h expected 0", bus8.RESULT); end
    checks++; if (bus8.BUSY !== 1'b0 || bus8.DONE !== 1'b0 || bus8.STALL !== 1'b0) begin
      errors++; $display("FAIL rst_run_flags: got busy=%b done=%b stall=%b expected 0/0/0", bus8.BUSY, bus8.DONE, bus8.STALL);
    end
    tick();
    rst_n = 1;
    key8_model = '0;
    tick();
    exp_v = ref_cipher(32'h1111_2222, key8_model, 1'b0, 8);
    run_op8(1'b0, 32'h1111_2222, lat, res, sd);
    checks++; if (lat != 9) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 9", lat); end
    checks++; if (res !== exp_v) begin errors++; $display("FAIL rst_fresh_result: got %h expected %h", res, exp_v); end
  endtask

  initial begin
    test_reset();
    test_one_round();
    test_enc_dec();
    test_abort();
    test_key_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
